// File: rtl/step_segment_runner.sv
// Segment runner: pops motion records from the record FIFO and turns each one
// into direction levels plus a train of fixed-width step pulses on the selected axes.
module step_segment_runner #(
    parameter int unsigned NumAxes        = 4,
    parameter int unsigned RecordSizeBits = 128,
    parameter int unsigned PulseWidth     = 4,
    parameter int unsigned DirSetup       = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      fifo_empty,
    input  logic [RecordSizeBits-1:0] fifo_record,
    output logic                      fifo_read_en,
    input  logic                      clear_underrun,
    output logic [NumAxes-1:0]        step,
    output logic [NumAxes-1:0]        dir,
    output logic                      busy,
    output logic                      done,
    output logic                      underrun
);

    localparam int unsigned     CntW      = 32;
    localparam logic [CntW-1:0] MinPeriod = CntW'(PulseWidth + 1);
    localparam logic [CntW-1:0] PulseLen  = CntW'(PulseWidth);
    localparam logic [CntW-1:0] SetupLast = CntW'((DirSetup > 0) ? DirSetup - 1 : 0);
    localparam bit              HasSetup  = (DirSetup > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Record field decode; bits outside the defined fields are don't-care.
    logic [CntW-1:0]    rec_steps;
    logic [CntW-1:0]    rec_period;
    logic [NumAxes-1:0] rec_dir;
    logic [NumAxes-1:0] rec_mask;
    logic               rec_last;
    logic               unused_rec;

    assign rec_steps  = fifo_record[31:0];
    assign rec_period = fifo_record[63:32];
    assign rec_dir    = fifo_record[64 +: NumAxes];
    assign rec_mask   = fifo_record[72 +: NumAxes];
    assign rec_last   = fifo_record[80];
    assign unused_rec = ^fifo_record;

    state_e             state_q, state_d;
    logic [CntW-1:0]    steps_left_q, steps_left_d;
    logic [CntW-1:0]    period_q, period_d;
    logic [CntW-1:0]    phase_q, phase_d;
    logic [CntW-1:0]    setup_cnt_q, setup_cnt_d;
    logic [NumAxes-1:0] mask_q, mask_d;
    logic               last_q, last_d;
    logic [NumAxes-1:0] dir_q, dir_d;
    logic [NumAxes-1:0] step_q, step_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               underrun_q, underrun_d;
    logic               seg_end;
    logic               seg_last;

    // Pop request; the FIFO advances on the same edge that latches the record.
    assign fifo_read_en = (state_q == ST_IDLE) && enable && !fifo_empty;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        period_d     = period_q;
        phase_d      = phase_q;
        setup_cnt_d  = setup_cnt_q;
        mask_d       = mask_q;
        last_d       = last_q;
        dir_d        = dir_q;
        seg_end      = 1'b0;
        seg_last     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fifo_read_en) begin
                    if (rec_steps == '0) begin
                        seg_end  = 1'b1;
                        seg_last = rec_last;
                    end else begin
                        steps_left_d = rec_steps;
                        period_d     = (rec_period < MinPeriod) ? MinPeriod : rec_period;
                        mask_d       = rec_mask;
                        last_d       = rec_last;
                        dir_d        = rec_dir;
                        phase_d      = '0;
                        setup_cnt_d  = '0;
                        state_d      = HasSetup ? ST_SETUP : ST_RUN;
                    end
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == SetupLast) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end else begin
                    setup_cnt_d = setup_cnt_q + CntW'(1);
                end
            end
            ST_RUN: begin
                if (phase_q == period_q - CntW'(1)) begin
                    phase_d      = '0;
                    steps_left_d = steps_left_q - CntW'(1);
                    if (steps_left_q == CntW'(1)) begin
                        state_d  = ST_IDLE;
                        seg_end  = 1'b1;
                        seg_last = last_q;
                    end
                end else begin
                    phase_d = phase_q + CntW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Set has priority over a coincident clear.
        done_d     = seg_end && seg_last;
        underrun_d = (underrun_q && !clear_underrun) || (seg_end && !seg_last && fifo_empty);

        step_d = ((state_d == ST_RUN) && (phase_d < PulseLen)) ? mask_d : '0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            steps_left_q <= '0;
            period_q     <= '0;
            phase_q      <= '0;
            setup_cnt_q  <= '0;
            mask_q       <= '0;
            last_q       <= 1'b0;
            dir_q        <= '0;
            step_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            steps_left_q <= steps_left_d;
            period_q     <= period_d;
            phase_q      <= phase_d;
            setup_cnt_q  <= setup_cnt_d;
            mask_q       <= mask_d;
            last_q       <= last_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_step_segment_runner.sv
// Bench for step_segment_runner: a FIFO model feeds records; a timeline-based
// reference predicts every cycle's outputs into a queue checked by a monitor.
module tb_step_segment_runner;

    localparam int unsigned NA = 4;
    localparam int unsigned PW = 4;
    localparam int unsigned DS = 2;
    localparam int unsigned RB = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          clear_underrun = 1'b0;
    logic [RB-1:0] fifo_record = '0;
    logic          fifo_read_en;
    logic [NA-1:0] step;
    logic [NA-1:0] dir;
    logic          busy;
    logic          done;
    logic          underrun;

    step_segment_runner #(
        .NumAxes(NA), .RecordSizeBits(RB), .PulseWidth(PW), .DirSetup(DS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_record(fifo_record), .fifo_read_en(fifo_read_en),
        .clear_underrun(clear_underrun), .step(step), .dir(dir), .busy(busy),
        .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rd;
        logic [NA-1:0] step;
        logic [NA-1:0] dir;
        logic          busy;
        logic          done;
        logic          under;
    } obs_t;

    obs_t          exp_q[$];
    logic [RB-1:0] fq[$];
    int            checks = 0;
    int            errors = 0;
    bit            checking = 1'b0;
    longint        mon_cyc = 0;

    // Reference model: each segment is a timeline (pop cycle, pulse start, end cycle).
    longint        cyc = 0;
    bit            seg_act = 1'b0;
    longint        seg_p, seg_rs, seg_e, seg_pe;
    logic [NA-1:0] m_mask = '0;
    logic [NA-1:0] m_dir = '0;
    bit            m_last = 1'b0;
    bit            m_done = 1'b0;
    bit            m_under = 1'b0;

    always @(negedge clk) begin
        if (checking && exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = {fifo_read_en, step, dir, busy, done, underrun};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got rd=%b step=%h dir=%h busy=%b done=%b underrun=%b expected rd=%b step=%h dir=%h busy=%b done=%b underrun=%b",
                         mon_cyc, a.rd, a.step, a.dir, a.busy, a.done, a.under,
                         e.rd, e.step, e.dir, e.busy, e.done, e.under);
            end
            mon_cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    function automatic logic [RB-1:0] mk_rec(input logic [31:0] n, input logic [31:0] per,
                                             input logic [NA-1:0] d, input logic [NA-1:0] m,
                                             input bit last);
        logic [RB-1:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[31:0]    = n;
        r[63:32]   = per;
        r[64 +: NA] = d;
        r[72 +: NA] = m;
        r[80]      = last;
        return r;
    endfunction

    task automatic end_seg(input bit last, input bit emp);
        if (last) m_done = 1'b1;
        else if (emp) m_under = 1'b1;
    endtask

    // One clock cycle: drive inputs, predict outputs, advance model on the edge.
    task automatic tick(input bit en, input bit clr, input bit hold);
        obs_t          e;
        bit            emp;
        bit            busy_m;
        bit            rd_m;
        logic [NA-1:0] st;
        logic [RB-1:0] r;
        longint        n;
        longint        per;
        emp            = hold || (fq.size() == 0);
        enable         = en;
        clear_underrun = clr;
        fifo_empty     = emp;
        fifo_record    = (fq.size() > 0) ? fq[0] : '0;
        busy_m = seg_act && (cyc > seg_p) && (cyc <= seg_e);
        rd_m   = !busy_m && en && !emp;
        st     = '0;
        if (seg_act && cyc >= seg_rs && cyc <= seg_e && ((cyc - seg_rs) % seg_pe) < longint'(PW))
            st = m_mask;
        e = {rd_m, st, m_dir, busy_m, m_done, m_under};
        exp_q.push_back(e);
        @(posedge clk);
        m_done = 1'b0;
        if (clr) m_under = 1'b0;
        if (seg_act && cyc == seg_e) begin
            seg_act = 1'b0;
            end_seg(m_last, emp);
        end
        if (rd_m) begin
            r   = fq.pop_front();
            n   = {32'd0, r[31:0]};
            per = {32'd0, r[63:32]};
            if (n == 0) begin
                end_seg(r[80], emp);
            end else begin
                seg_act = 1'b1;
                seg_p   = cyc;
                seg_pe  = (per < longint'(PW) + 1) ? longint'(PW) + 1 : per;
                seg_rs  = cyc + longint'(DS) + 1;
                seg_e   = cyc + longint'(DS) + n * seg_pe;
                m_dir   = r[64 +: NA];
                m_mask  = r[72 +: NA];
                m_last  = r[80];
            end
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int k, input bit en);
        for (int i = 0; i < k; i++) tick(en, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_step"}, 32'(step), 32'd0);
        chk({tag, "_dir"}, 32'(dir), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
        chk({tag, "_rd"}, 32'(fifo_read_en), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        checking = 1'b1;
        run(5, 1'b1);

        // Reference segment: 3 steps, period 10, dir 0101, mask 0011, last.
        fq.push_back(mk_rec(32'd3, 32'd10, 4'b0101, 4'b0011, 1'b1));
        run(40, 1'b1);

        // Period below the pulse width is stretched to PulseWidth+1.
        fq.push_back(mk_rec(32'd2, 32'd2, 4'b1010, 4'b1111, 1'b1));
        run(20, 1'b1);
        fq.push_back(mk_rec(32'd2, 32'd0, 4'b0011, 4'b0100, 1'b1));
        run(20, 1'b1);

        // Back-to-back segments, first not last.
        fq.push_back(mk_rec(32'd2, 32'd6, 4'b1100, 4'b1001, 1'b0));
        fq.push_back(mk_rec(32'd1, 32'd7, 4'b0110, 4'b0110, 1'b1));
        run(50, 1'b1);

        // Underrun: sticky, then cleared, then coincident clear and set.
        fq.push_back(mk_rec(32'd1, 32'd5, 4'b0001, 4'b0001, 1'b0));
        run(70, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        run(5, 1'b1);
        fq.push_back(mk_rec(32'd2, 32'd5, 4'b1000, 4'b1000, 1'b0));
        for (int i = 0; i < 30; i++) tick(1'b1, seg_act && (cyc == seg_e), 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        run(3, 1'b1);

        // Zero-step record: consumed, no motion, dir kept, done pulse.
        fq.push_back(mk_rec(32'd0, 32'd9, 4'b1111, 4'b1111, 1'b1));
        run(5, 1'b1);

        // Enable gating: no pops while low, current segment always finishes.
        fq.push_back(mk_rec(32'd3, 32'd6, 4'b0101, 4'b1110, 1'b1));
        fq.push_back(mk_rec(32'd2, 32'd5, 4'b1010, 4'b0111, 1'b1));
        run(10, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        run(4, 1'b1);
        run(60, 1'b0);
        run(40, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (fq.size() < 3 && ($urandom % 4) == 0)
                fq.push_back(mk_rec(32'($urandom_range(0, 4)), 32'($urandom_range(0, 12)),
                                    4'($urandom), 4'($urandom), 1'($urandom)));
            tick(($urandom % 10) != 0, ($urandom % 20) == 0, ($urandom % 8) == 0);
        end
        fq.delete();
        run(80, 1'b1);

        // Asynchronous reset mid-segment.
        fq.push_back(mk_rec(32'd100, 32'd5, 4'b1111, 4'b1111, 1'b0));
        run(20, 1'b1);
        enable = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midrun_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fq.delete();
        seg_act = 1'b0;
        m_dir   = '0;
        m_mask  = '0;
        m_done  = 1'b0;
        m_under = 1'b0;
        run(10, 1'b1);

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
